dmem_mmio: RTL and testbench
============================

// Module: dmem_mmio
// PURPOSE
//  Data-side memory responder for the pipelined MIPS core. Serves the core's M-stage
//  access (address = aluout, writedata, memwrite) and returns readdata in the same cycle.
//  Address space: word RAM plus an MMIO page holding a TX FIFO that drains to an
//  external valid/ready byte-free word stream, a status register and a cycle counter.
// PARAMETERS
//  MEM_AW      8    RAM word-address bits (RAM depth = 2**MEM_AW words)
//  FIFO_AW     3    TX FIFO address bits (depth = 2**FIFO_AW entries)
// PORTS
//  clk        in   1       clock, all state updates on posedge
//  rst_n      in   1       asynchronous, active-low reset
//  addr       in   DATA_W  byte address from core (aluout)
//  writedata  in   DATA_W  store data from core
//  memwrite   in   1       store strobe from core, sampled at posedge
//  readdata   out  DATA_W  load data, combinational from addr
//  tx_valid   out  1       TX stream word available
//  tx_data    out  DATA_W  TX stream word (FIFO head)
//  tx_ready   in   1       TX sink accepts; transfer when tx_valid & tx_ready at posedge
// BEHAVIOUR
//  Decode: addr[31:16]==`MMIO_PAGE (16'hFFFF) -> MMIO, else RAM. addr[1:0] ignored.
//  RAM: index = addr[MEM_AW+1:2]; higher bits ignored (aliasing/wrap). Async read,
//   write at posedge when memwrite. Same-cycle read of written word returns OLD data.
//   RAM contents not reset; bench must initialise before reading.
//  MMIO offsets (addr[15:0]):
//   0x0000 TXDATA  write: push writedata into FIFO. read: 0.
//   0x0004 STATUS  read: {zeros, count[FIFO_AW:0] at [FIFO_AW+3:3], ovf[2], full[1], empty[0]}
//                  write: writedata[2]==1 clears ovf; other bits ignored.
//   0x0008 CYCLE   read: counter value. write: counter <= writedata (no increment that edge).
//   other          read 0, write ignored.
//  Reads always reflect pre-edge state (combinational from current registers).
//  FIFO: push = memwrite & TXDATA hit; pop = tx_valid & tx_ready. tx_valid = !empty,
//   tx_data = head entry (registered storage, no bypass: pushed word visible next cycle).
//   Pointers wrap mod depth; count 0..depth.
//   push & !full -> accept. push & full & !pop -> drop word, ovf <= 1 (sticky).
//   push & pop when full -> both happen, count stays full, no ovf.
//   push & pop when empty -> impossible (tx_valid=0); push only.
//   ovf set and clear in same edge -> set wins.
//  CYCLE: 32-bit free-running, +1 every posedge, wraps 0xFFFFFFFF -> 0.
//  Reset (async, any time incl. mid-transfer): FIFO pointers/count 0, tx_valid 0,
//   tx_data 0, ovf 0, CYCLE 0. readdata follows addr combinationally (RAM undefined).
//  Latency: load 0 cycles (combinational), store/push/control effects visible after 1 edge.
// STRUCTURE
//  def.h additions: `MMIO_PAGE 16'hFFFF, `MMIO_TXDATA 16'h0000, `MMIO_STATUS 16'h0004,
//   `MMIO_CYCLE 16'h0008, status bit positions `ST_EMPTY 0, `ST_FULL 1, `ST_OVF 2.
//  Sub-module: mmio_txfifo (sync FIFO: push/pop/din/dout/full/empty/count, async reset).
//  Top: address decode, RAM array, STATUS/CYCLE registers, readdata mux.
// TESTING
//  1 RAM: sw 0x12345678 @0x40, lw @0x40 next cycle -> 0x12345678; lw @0x440 (MEM_AW=8)
//    -> same word (alias); same-cycle read during write -> old value.
//  2 TX: tx_ready=0, push 0xA,0xB,0xC -> STATUS count=3, empty=0; raise tx_ready ->
//    tx_data 0xA,0xB,0xC on consecutive edges, then tx_valid=0, STATUS=empty=1.
//  3 Overflow: tx_ready=0, push 9 words (depth 8) -> full=1, ovf=1, 9th dropped;
//    write STATUS 0x4 -> ovf=0; drain -> exactly words 1..8 out.
//  4 Full push+pop: FIFO full, tx_ready=1 with push 0x99 same edge -> count stays 8,
//    ovf=0, 0x99 emerges last.
//  5 CYCLE: write 0xFFFFFFFE -> reads 0xFFFFFFFE, then 0xFFFFFFFF, then 0 on next edges.
//  6 Reset: assert rst_n=0 mid-drain, between edges -> tx_valid=0 immediately, STATUS=0x1,
//    CYCLE=0 after release; first push afterwards appears as tx_data next cycle.

Source files
------------

// File: rtl/dmem_mmio_pkg.sv
package dmem_mmio_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [15:0] MMIO_PAGE   = 16'hFFFF;
  localparam logic [15:0] MMIO_TXDATA = 16'h0000;
  localparam logic [15:0] MMIO_STATUS = 16'h0004;
  localparam logic [15:0] MMIO_CYCLE  = 16'h0008;

  localparam int unsigned ST_EMPTY = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_OVF   = 2;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_TXDATA,
    SEL_STATUS,
    SEL_CYCLE,
    SEL_NONE
  } sel_e;

  // offset arrives word-aligned (byte lanes already dropped by the caller)
  function automatic sel_e decode_sel(input logic [15:0] page, input logic [15:0] offset);
    sel_e sel;
    if (page != MMIO_PAGE) begin
      sel = SEL_RAM;
    end else begin
      case (offset)
        MMIO_TXDATA: sel = SEL_TXDATA;
        MMIO_STATUS: sel = SEL_STATUS;
        MMIO_CYCLE:  sel = SEL_CYCLE;
        default:     sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/dmem_mmio_txfifo.sv
module mmio_txfifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop frees the slot this edge, so a push into a full FIFO still lands
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dmem_mmio.sv
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int unsigned MEM_AW  = 8,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] writedata,
  input  logic              memwrite,
  output logic [DATA_W-1:0] readdata,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready
);

  localparam int unsigned RAM_DEPTH = 1 << MEM_AW;

  sel_e               sel;
  logic               unused_addr_lsb;
  logic [DATA_W-1:0]  ram [RAM_DEPTH];
  logic [MEM_AW-1:0]  ram_idx;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_AW:0]   fifo_count;
  logic               ovf;
  logic               ovf_set;
  logic               ovf_clr;
  logic               cycle_wr;
  logic [DATA_W-1:0]  cycle_cnt;
  logic [DATA_W-1:0]  status_word;

  assign sel             = decode_sel(addr[31:16], {addr[15:2], 2'b00});
  assign unused_addr_lsb = ^addr[1:0];
  assign ram_idx         = addr[MEM_AW+1:2];

  assign fifo_push = memwrite & (sel == SEL_TXDATA);
  assign fifo_pop  = tx_valid & tx_ready;
  assign ovf_set   = fifo_push & fifo_full & ~fifo_pop;
  assign ovf_clr   = memwrite & (sel == SEL_STATUS) & writedata[ST_OVF];
  assign cycle_wr  = memwrite & (sel == SEL_CYCLE);
  assign tx_valid  = ~fifo_empty;

  mmio_txfifo #(
    .DATA_W (DATA_W),
    .AW     (FIFO_AW)
  ) u_txfifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (writedata),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (memwrite && sel == SEL_RAM) ram[ram_idx] <= writedata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if (cycle_wr) begin
      cycle_cnt <= writedata;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  always_comb begin
    status_word                = '0;
    status_word[FIFO_AW+3:3]   = fifo_count;
    status_word[ST_OVF]        = ovf;
    status_word[ST_FULL]       = fifo_full;
    status_word[ST_EMPTY]      = fifo_empty;
  end

  always_comb begin
    readdata = '0;
    case (sel)
      SEL_RAM:    readdata = ram[ram_idx];
      SEL_STATUS: readdata = status_word;
      SEL_CYCLE:  readdata = cycle_cnt;
      default:    readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;

  localparam int unsigned MEM_AW  = 8;
  localparam int unsigned DEPTH   = 8;
  localparam logic [31:0] A_TX    = 32'hFFFF_0000;
  localparam logic [31:0] A_ST    = 32'hFFFF_0004;
  localparam logic [31:0] A_CY    = 32'hFFFF_0008;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] readdata;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;

  dmem_mmio #(.MEM_AW(MEM_AW), .FIFO_AW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .writedata (writedata),
    .memwrite  (memwrite),
    .readdata  (readdata),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          chk_rd;
    logic [31:0] rd;
    logic        txv;
    bit          chk_tx0;
  } cyc_exp_t;

  cyc_exp_t    exp_cyc[$];
  logic [31:0] exp_tx[$];

  logic [31:0] mram[int unsigned];
  logic [31:0] mfifo[$];
  bit          m_ovf;
  logic [31:0] m_cyc;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h at %0t", name, act, expv, $time);
    end
  endtask

  // one clock of stimulus; reference state is advanced as the coming edge will
  task automatic cycle_do(input bit rst, input logic [31:0] a, input logic [31:0] wd,
                          input bit we, input bit rdy);
    cyc_exp_t    e;
    bit          mmio;
    logic [15:0] off;
    int unsigned idx;
    int          n;
    bit          pop;
    bit          full_pre;
    bit          set_ovf;
    @(posedge clk);
    #1;
    addr      = a;
    writedata = wd;
    memwrite  = we;
    tx_ready  = rdy;
    rst_n     = rst;
    if (!rst) begin
      mfifo.delete();
      m_ovf = 1'b0;
      m_cyc = '0;
    end
    mmio = (a[31:16] == 16'hFFFF);
    off  = {a[15:2], 2'b00};
    idx  = int'(a[MEM_AW+1:2]);
    n    = mfifo.size();
    e.chk_rd  = 1'b1;
    e.rd      = '0;
    e.chk_tx0 = !rst;
    e.txv     = (n != 0);
    if (!mmio) begin
      if (mram.exists(idx)) e.rd = mram[idx];
      else e.chk_rd = 1'b0;
    end else if (off == 16'h0004) begin
      e.rd = 32'(n * 8 + (m_ovf ? 4 : 0) + (n == DEPTH ? 2 : 0) + (n == 0 ? 1 : 0));
    end else if (off == 16'h0008) begin
      e.rd = m_cyc;
    end
    exp_cyc.push_back(e);
    if (rst) begin
      if (we && !mmio) mram[idx] = wd;
      full_pre = (n == DEPTH);
      pop      = (n > 0) && rdy;
      set_ovf  = 1'b0;
      if (pop) exp_tx.push_back(mfifo.pop_front());
      if (we && mmio && off == 16'h0000) begin
        if (!full_pre || pop) mfifo.push_back(wd);
        else set_ovf = 1'b1;
      end
      if (we && mmio && off == 16'h0004 && wd[2]) m_ovf = 1'b0;
      if (set_ovf) m_ovf = 1'b1;
      if (we && mmio && off == 16'h0008) m_cyc = wd;
      else m_cyc = m_cyc + 1;
    end
  endtask

  task automatic idle(input int unsigned n, input bit rdy, input logic [31:0] a);
    for (int unsigned i = 0; i < n; i++) cycle_do(1'b1, a, '0, 1'b0, rdy);
  endtask

  // monitor: sampled on the falling edge, mid-cycle
  initial begin
    cyc_exp_t e;
    forever begin
      @(negedge clk);
      if (exp_cyc.size() > 0) begin
        e = exp_cyc.pop_front();
        if (e.chk_rd) chk("readdata", readdata, e.rd);
        chk("tx_valid", {31'b0, tx_valid}, {31'b0, e.txv});
        if (e.chk_tx0) chk("tx_data_reset", tx_data, '0);
      end
      if (rst_n && tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected actual=%08h expected=none", tx_data);
        end else begin
          chk("tx_data", tx_data, exp_tx.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned kind;
    bit          rdy_bias;
    logic [31:0] a;
    rst_n     = 1'b0;
    addr      = '0;
    writedata = '0;
    memwrite  = 1'b0;
    tx_ready  = 1'b0;
    m_ovf     = 1'b0;
    m_cyc     = '0;

    cycle_do(1'b0, A_ST, '0, 1'b0, 1'b0);
    cycle_do(1'b0, A_CY, '0, 1'b0, 1'b0);

    for (int unsigned i = 0; i < (1 << MEM_AW); i++)
      cycle_do(1'b1, 32'(i * 4), $urandom, 1'b1, 1'b0);

    // RAM: store, load, alias, write-during-read
    cycle_do(1'b1, 32'h40,  32'h1234_5678, 1'b1, 1'b0);
    cycle_do(1'b1, 32'h40,  '0, 1'b0, 1'b0);
    cycle_do(1'b1, 32'h440, '0, 1'b0, 1'b0);
    cycle_do(1'b1, 32'h40,  32'hDEAD_BEEF, 1'b1, 1'b0);
    cycle_do(1'b1, 32'h440, '0, 1'b0, 1'b0);

    // TX basic
    cycle_do(1'b1, A_TX, 32'hA, 1'b1, 1'b0);
    cycle_do(1'b1, A_TX, 32'hB, 1'b1, 1'b0);
    cycle_do(1'b1, A_TX, 32'hC, 1'b1, 1'b0);
    cycle_do(1'b1, A_ST, '0, 1'b0, 1'b0);
    idle(5, 1'b1, A_ST);

    // overflow, clear, drain
    for (int unsigned i = 1; i <= 9; i++) cycle_do(1'b1, A_TX, 32'(i), 1'b1, 1'b0);
    cycle_do(1'b1, A_ST, 32'h4, 1'b1, 1'b0);
    idle(10, 1'b1, A_ST);

    // full push+pop
    for (int unsigned i = 0; i < 8; i++) cycle_do(1'b1, A_TX, 32'h50 + 32'(i), 1'b1, 1'b0);
    cycle_do(1'b1, A_TX, 32'h99, 1'b1, 1'b1);
    cycle_do(1'b1, A_ST, '0, 1'b0, 1'b0);
    idle(10, 1'b1, A_ST);

    // cycle counter wrap
    cycle_do(1'b1, A_CY, 32'hFFFF_FFFE, 1'b1, 1'b0);
    idle(3, 1'b0, A_CY);

    // reset mid-drain
    for (int unsigned i = 0; i < 4; i++) cycle_do(1'b1, A_TX, 32'h70 + 32'(i), 1'b1, 1'b0);
    cycle_do(1'b1, A_ST, '0, 1'b0, 1'b1);
    cycle_do(1'b0, A_ST, '0, 1'b0, 1'b1);
    cycle_do(1'b0, A_CY, '0, 1'b0, 1'b1);
    cycle_do(1'b1, A_CY, '0, 1'b0, 1'b0);
    cycle_do(1'b1, A_TX, 32'h55, 1'b1, 1'b0);
    cycle_do(1'b1, A_ST, '0, 1'b0, 1'b1);
    idle(2, 1'b1, A_ST);

    // randomized mix
    rdy_bias = 1'b0;
    for (int unsigned i = 0; i < 600; i++) begin
      if (i % 40 == 0) rdy_bias = ~rdy_bias;
      kind = $urandom_range(0, 9);
      a = $urandom & 32'h7FFF_FFFF;
      case (kind)
        0, 1, 2, 3: cycle_do(1'b1, a, $urandom, $urandom_range(0, 1) == 1,
                             rdy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0));
        4, 5:       cycle_do(1'b1, A_TX, $urandom, $urandom_range(0, 4) != 0,
                             rdy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0));
        6:          cycle_do(1'b1, A_ST, $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
        7:          cycle_do(1'b1, A_CY, $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
        8:          cycle_do(1'b1, 32'hFFFF_0000 | ($urandom & 32'h0000_FFF0) | 32'h10, $urandom,
                             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        default:    cycle_do($urandom_range(0, 99) != 0, A_ST, '0, 1'b0, $urandom_range(0, 1) == 1);
      endcase
    end
    idle(12, 1'b1, A_ST);

    @(negedge clk);
    #1;
    chk("tx_left", 32'(exp_tx.size()), '0);
    chk("exp_left", 32'(exp_cyc.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
